// File: rtl/clock_meas_pkg.sv
// Shared definitions for the clock ratio meter: default sizing and FSM state encoding.
package clock_meas_pkg;

   localparam int unsigned CNT_W_DEF       = 16;
   localparam int unsigned LOCK_N_DEF      = 4;
   localparam int unsigned TIMEOUT_CYC_DEF = 65535;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } meas_state_e;

endpackage

// File: rtl/edge_detect.sv
// Single-register sampler of sig_in with a combinational rising-edge strobe.
module edge_detect (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   always_ff @(posedge clk_in) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a clk_in-domain divided clock, tracks ratio lock and timeout.
module clock_ratio_meter
   import clock_meas_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned LOCK_N      = LOCK_N_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);

   meas_state_e        state, state_nxt;
   logic               sig_q;
   logic               rise;
   logic [CNT_W-1:0]   cnt, hcnt;
   logic [CNT_W-1:0]   cnt_inc, hcnt_inc;
   logic [MATCH_W-1:0] match, match_nxt;
   logic               cnt_at_limit;

   edge_detect u_edge (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (sig_in),
      .q      (sig_q),
      .rise   (rise)
   );

   always_ff @(posedge clk_in) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (rise) state_nxt = MEASURE;
            MEASURE: if (!rise && cnt_at_limit) state_nxt = TIMEOUT;
            TIMEOUT: if (rise) state_nxt = MEASURE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Saturating counters; a zero match count marks the first measurement of a run.
   always_comb begin
      cnt_inc      = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      hcnt_inc     = (sig_in && hcnt != '1) ? hcnt + CNT_W'(1) : hcnt;
      cnt_at_limit = (cnt == CNT_W'(TIMEOUT_CYC));
      if (match == '0 || cnt != period)
         match_nxt = MATCH_W'(1);
      else if (match >= MATCH_W'(LOCK_N))
         match_nxt = MATCH_W'(LOCK_N);
      else
         match_nxt = match + MATCH_W'(1);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         cnt          <= '0;
         hcnt         <= '0;
         match        <= '0;
      end else if (!en) begin
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         match        <= '0;
         cnt          <= '0;
         hcnt         <= '0;
      end else begin
         period_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  cnt  <= CNT_W'(1);
                  hcnt <= CNT_W'(1);
               end
            end
            MEASURE: begin
               if (rise) begin
                  period       <= cnt;
                  high_time    <= hcnt;
                  period_valid <= 1'b1;
                  match        <= match_nxt;
                  locked       <= (match_nxt >= MATCH_W'(LOCK_N));
                  cnt          <= CNT_W'(1);
                  hcnt         <= CNT_W'(1);
               end else if (cnt_at_limit) begin
                  timeout <= 1'b1;
                  locked  <= 1'b0;
                  match   <= '0;
               end else begin
                  cnt  <= cnt_inc;
                  hcnt <= hcnt_inc;
               end
            end
            TIMEOUT: begin
               if (rise) begin
                  timeout <= 1'b0;
                  cnt     <= CNT_W'(1);
                  hcnt    <= CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Scoreboard bench for clock_ratio_meter: timestamp-based reference model feeds an event queue.
module tb_clock_ratio_meter;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned LOCK_N = 4;
   localparam int unsigned TO_CYC = 100;

   localparam int EV_PULSE = 0;
   localparam int EV_TO    = 1;
   localparam int EV_CLR   = 2;

   typedef struct {
      int kind;
      int cyc;
      int per;
      int hi;
      int lk;
   } ev_t;

   logic             clk_in = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic             period_valid, locked, timeout;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   ev_t  sbq[$];
   ev_t  mon_ev;
   logic to_prev = 1'b0;

   // reference model state, expressed in rise timestamps
   logic m_prev_s = 1'b0;
   bit   m_armed = 0;
   bit   m_to = 0;
   int   m_last_rise = 0;
   int   m_hsum = 0;
   int   m_run = 0;
   int   m_prev_per = 0;
   int   m_last_per = 0;

   int g_div = 2, g_hi = 1, g_ph = 0;

   clock_ratio_meter #(
      .CNT_W       (CNT_W),
      .LOCK_N      (LOCK_N),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .en           (en),
      .sig_in       (sig_in),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .locked       (locked),
      .timeout      (timeout)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void push(input int kind, input int c, input int p, input int h, input int l);
      ev_t e;
      e.kind = kind; e.cyc = c; e.per = p; e.hi = h; e.lk = l;
      sbq.push_back(e);
   endfunction

   task automatic model_step(input logic s, input logic e, input logic r, input int k);
      bit rise_m;
      int per;
      if (r) begin
         if (m_to) push(EV_CLR, k, 0, 0, 0);
         m_to = 0; m_armed = 0; m_run = 0; m_prev_s = 1'b0; m_last_per = 0;
         return;
      end
      rise_m   = s && !m_prev_s;
      m_prev_s = s;
      if (!e) begin
         if (m_to) push(EV_CLR, k, 0, 0, 0);
         m_to = 0; m_armed = 0; m_run = 0;
         return;
      end
      if (m_armed) begin
         if (rise_m) begin
            per = k - m_last_rise;
            if (m_run == 0 || per != m_prev_per) m_run = 1;
            else if (m_run < int'(LOCK_N))       m_run++;
            m_prev_per = per;
            m_last_per = per;
            push(EV_PULSE, k, per, m_hsum, (m_run >= int'(LOCK_N)) ? 1 : 0);
            m_last_rise = k;
            m_hsum = 1;
         end else if (k - m_last_rise == int'(TO_CYC)) begin
            push(EV_TO, k, 0, 0, 0);
            m_to = 1; m_armed = 0; m_run = 0;
         end else begin
            m_hsum += int'(s);
         end
      end else if (rise_m) begin
         if (m_to) push(EV_CLR, k, 0, 0, 0);
         m_to = 0; m_armed = 1; m_last_rise = k; m_hsum = 1;
      end
   endtask

   task automatic drive(input logic s, input logic e, input logic r);
      sig_in = s; en = e; rst = r;
      model_step(s, e, r, cyc + 1);
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_div(input int d, input int h);
      g_div = d; g_hi = h; g_ph = 0;
   endtask

   task automatic tick(input logic e, input logic r);
      logic s;
      s = (g_ph < g_hi);
      g_ph = (g_ph + 1) % g_div;
      drive(s, e, r);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   // Monitor: pops one expected event whenever the DUT pulses or toggles timeout.
   always @(negedge clk_in) begin
      if (period_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            mon_ev = sbq.pop_front();
            chk("pulse_kind", mon_ev.kind, EV_PULSE);
            chk("pulse_cycle", cyc, mon_ev.cyc);
            chk("period", int'(period), mon_ev.per);
            chk("high_time", int'(high_time), mon_ev.hi);
            chk("locked_at_pulse", int'(locked), mon_ev.lk);
         end
      end
      if (timeout !== to_prev) begin
         if (sbq.size() == 0) begin
            chk("unexpected_timeout_edge", 1, 0);
         end else begin
            mon_ev = sbq.pop_front();
            chk("timeout_kind", mon_ev.kind, (timeout === 1'b1) ? EV_TO : EV_CLR);
            chk("timeout_cycle", cyc, mon_ev.cyc);
            if (timeout === 1'b1) chk("locked_at_timeout", int'(locked), 0);
         end
      end
      to_prev = timeout;
   end

   initial begin
      int sel, d;
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      chk("rst_period", int'(period), 0);
      chk("rst_high_time", int'(high_time), 0);
      chk("rst_valid", int'(period_valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_timeout", int'(timeout), 0);

      set_div(2, 1);  run(20);
      set_div(16, 8); run(100);
      set_div(4, 2);  run(40);
      set_div(8, 4);  run(60);

      // hold low until timeout, then resume
      set_div(1000, 0); run(120);
      chk("timeout_period_held", int'(period), 8);
      set_div(8, 4);  run(60);
      chk("locked_before_en_drop", int'(locked), 1);

      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0);
         chk("en_low_locked", int'(locked), 0);
         chk("en_low_valid", int'(period_valid), 0);
         chk("en_low_period_held", int'(period), m_last_per);
      end
      run(60);

      run(3);
      tick(1'b1, 1'b1);
      chk("midrst_period", int'(period), 0);
      chk("midrst_high_time", int'(high_time), 0);
      chk("midrst_valid", int'(period_valid), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_timeout", int'(timeout), 0);
      run(40);

      // period exactly at the timeout limit, then one past it
      set_div(100, 50); run(520);
      set_div(101, 50); run(320);

      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: for (int i = 0; i < $urandom_range(1, 4); i++) tick(1'b0, 1'b0);
            1: tick(1'b1, 1'b1);
            2: begin set_div(1000, 0); run($urandom_range(90, 110)); end
            3: for (int i = 0; i < 30; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            default: begin
               d = $urandom_range(2, 24);
               set_div(d, $urandom_range(1, d - 1));
               run($urandom_range(20, 120));
            end
         endcase
      end

      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
      @(negedge clk_in);
      #1;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clock_ratio_meter.md
CLOCK_RATIO_METER -- requirements
Module: clock_ratio_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the period and high-time counters.
REQ-002 The block SHALL have parameter LOCK_N, default 4, giving the number of consecutive equal periods required for lock.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 65535, giving the number of cycles without a rising edge before timeout (must be <= 2^CNT_W-1).
REQ-004 Port clk_in  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port en  input  1  SHALL be the measurement enable.
REQ-007 Port sig_in  input  1  SHALL be the divided clock under measurement, generated in the clk_in domain.
REQ-008 Port period  output  CNT_W  SHALL carry the clk_in cycles between the last two sig_in rising edges.
REQ-009 Port high_time  output  CNT_W  SHALL carry the clk_in cycles sig_in was sampled high within that period.
REQ-010 Port period_valid  output  1  SHALL pulse for one cycle per new measurement.
REQ-011 Port locked  output  1  SHALL indicate a stable ratio.
REQ-012 Port timeout  output  1  SHALL indicate that no sig_in edge arrived within TIMEOUT_CYC cycles.

Function
REQ-013 sig_in SHALL be registered once (sig_q); rise = sig_in AND NOT sig_q.
REQ-014 The FSM SHALL have the states IDLE, MEASURE and TIMEOUT.
REQ-015 In IDLE, on rise the FSM SHALL go to MEASURE with cnt<=1 and hcnt<=1, and no measurement SHALL be reported.
REQ-016 In MEASURE with no rise, cnt SHALL increment each cycle and hcnt SHALL increment each cycle sig_in=1.
REQ-017 Both counters SHALL saturate at all-ones.
REQ-018 In MEASURE on rise: period<=cnt, high_time<=hcnt, period_valid<=1 for one cycle, then cnt<=1 and hcnt<=1; the reported period spans two rises (clk_in/2 gives period=2, high_time=1).
REQ-019 In MEASURE, when cnt reaches TIMEOUT_CYC with no rise, the FSM SHALL go to TIMEOUT with timeout<=1, locked<=0 and match<=0; period and high_time SHALL hold their last values.
REQ-020 In TIMEOUT, on rise the FSM SHALL go to MEASURE with timeout<=0 and cnt=hcnt=1; that rise SHALL produce no period_valid.
REQ-021 Lock tracking: on each measurement, match<=1 if it is the first measurement since IDLE/TIMEOUT or the new period differs from the previous one, else match<=match+1, saturating at LOCK_N.
REQ-022 locked SHALL be 1 when match>=LOCK_N and SHALL update in the same cycle as period_valid.
REQ-023 A period mismatch SHALL drop locked in the same cycle as the mismatching period_valid.
REQ-024 en=0 SHALL force IDLE, clear period_valid, locked, timeout and match, and hold period and high_time; measurement restarts from the next rise after en=1.
REQ-025 high_time SHALL NOT affect lock.
REQ-026 Rise coincident with cnt reaching TIMEOUT_CYC: the rise SHALL win, giving a normal measurement and no timeout.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE; period, high_time, period_valid, locked, timeout, cnt, hcnt, match and sig_q SHALL be 0.
REQ-028 rst mid-measurement SHALL discard the partial count; rst has priority over en and rise.

Structure
REQ-029 The state encoding (IDLE=0, MEASURE=1, TIMEOUT=2) and the CNT_W, LOCK_N and TIMEOUT_CYC defaults SHALL reside in shared package clock_meas_pkg.
REQ-030 The sync register plus rise detect SHALL be sub-module edge_detect (ports clk_in, rst, d, q, rise); everything else SHALL be flat.

Verification
REQ-031 sig_in = clk_in/2 square wave, en=1 -> period=2, high_time=1, period_valid every 2 cycles, locked=1 at the 4th pulse.
REQ-032 sig_in = clk_in/16 -> period=16, high_time=8, locked after 4 measurements.
REQ-033 Lock at /8, then sig_in held low, TIMEOUT_CYC=100 -> timeout=1 and locked=0 100 cycles after the last rise; resume /8 -> first rise gives no pulse, second rise gives period=8, timeout=0.
REQ-034 Switch /4 to /8 mid-run -> locked falls on the first pulse with period!=4; relocks after 4 consecutive period=8 pulses.
REQ-035 rst=1 for 1 cycle mid-period while locked -> next cycle all outputs 0; the first rise after release gives no pulse; the next rise reports the correct period.
REQ-036 en=0 for 3 cycles while locked -> locked=0, period held; first rise after en=1 gives no pulse.
